// File: rtl/memory_port_arbiter_if.sv
// Load unit, store unit and memory-controller signals of memory_port_arbiter.
// slave is the arbiter's view; master is the view of the surrounding units.
interface memory_port_arbiter_if;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned WidthW = 2;

  logic              ld_request_i;
  logic [AddrW-1:0]  ld_address_i;
  logic [WidthW-1:0] ld_width_i;
  logic              ld_busy_o;
  logic              ld_valid_o;
  logic [DataW-1:0]  ld_data_o;

  logic              st_request_i;
  logic [AddrW-1:0]  st_address_i;
  logic [DataW-1:0]  st_data_i;
  logic [WidthW-1:0] st_width_i;
  logic              st_busy_o;
  logic              st_done_o;

  logic              mem_request_o;
  logic              mem_write_o;
  logic [AddrW-1:0]  mem_address_o;
  logic [DataW-1:0]  mem_data_o;
  logic [WidthW-1:0] mem_width_o;
  logic              mem_valid_i;
  logic [DataW-1:0]  mem_data_i;

  logic              idle_o;

  modport slave (
    input  ld_request_i, ld_address_i, ld_width_i,
    output ld_busy_o, ld_valid_o, ld_data_o,
    input  st_request_i, st_address_i, st_data_i, st_width_i,
    output st_busy_o, st_done_o,
    output mem_request_o, mem_write_o, mem_address_o, mem_data_o, mem_width_o,
    input  mem_valid_i, mem_data_i,
    output idle_o
  );

  modport master (
    output ld_request_i, ld_address_i, ld_width_i,
    input  ld_busy_o, ld_valid_o, ld_data_o,
    output st_request_i, st_address_i, st_data_i, st_width_i,
    input  st_busy_o, st_done_o,
    input  mem_request_o, mem_write_o, mem_address_o, mem_data_o, mem_width_o,
    output mem_valid_i, mem_data_i,
    input  idle_o
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one memory-controller port between a load slot and a store slot, one transaction at a time.
// Optional STORE_STARVATION_GUARD_EN caps consecutive load grants while a store waits.
module memory_port_arbiter #(
  parameter int unsigned MAX_LOAD_STREAK = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  memory_port_arbiter_if.slave bus
);
  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned WidthW = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_BUSY  = 2'd1,
    STORE_BUSY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ld_full_q, ld_full_d, st_full_q, st_full_d;
  logic [AddrW-1:0]  ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
  logic [DataW-1:0]  st_data_q, st_data_d;
  logic [WidthW-1:0] ld_width_q, ld_width_d, st_width_q, st_width_d;

  logic issue_c, pick_st_c, store_wins_c;
  logic ld_rsp_c, st_rsp_c, ld_accept_c, st_accept_c;
  logic              mem_write_c;
  logic [AddrW-1:0]  mem_addr_c;
  logic [DataW-1:0]  mem_data_c;
  logic [WidthW-1:0] mem_width_c;

  if (MAX_LOAD_STREAK == 0) begin : g_bad_streak
    $error("MAX_LOAD_STREAK must be at least 1");
  end

  assign issue_c   = (state_q == IDLE) && (ld_full_q || st_full_q);
  assign pick_st_c = st_full_q && (!ld_full_q || store_wins_c);
  assign ld_rsp_c  = (state_q == LOAD_BUSY) && bus.mem_valid_i;
  assign st_rsp_c  = (state_q == STORE_BUSY) && bus.mem_valid_i;
  // The response cycle frees the slot, so a same-cycle request refills it.
  assign ld_accept_c = bus.ld_request_i && (!ld_full_q || ld_rsp_c);
  assign st_accept_c = bus.st_request_i && (!st_full_q || st_rsp_c);

  always_comb begin
    state_d    = state_q;
    ld_full_d  = ld_full_q;
    ld_addr_d  = ld_addr_q;
    ld_width_d = ld_width_q;
    st_full_d  = st_full_q;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    st_width_d = st_width_q;

    if (ld_rsp_c) ld_full_d = 1'b0;
    if (ld_accept_c) begin
      ld_full_d  = 1'b1;
      ld_addr_d  = bus.ld_address_i;
      ld_width_d = bus.ld_width_i;
    end
    if (st_rsp_c) st_full_d = 1'b0;
    if (st_accept_c) begin
      st_full_d  = 1'b1;
      st_addr_d  = bus.st_address_i;
      st_data_d  = bus.st_data_i;
      st_width_d = bus.st_width_i;
    end

    case (state_q)
      IDLE:       if (issue_c) state_d = pick_st_c ? STORE_BUSY : LOAD_BUSY;
      LOAD_BUSY:  if (ld_rsp_c) state_d = IDLE;
      STORE_BUSY: if (st_rsp_c) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ld_full_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_width_q <= '0;
      st_full_q  <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      st_width_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_full_q  <= ld_full_d;
      ld_addr_q  <= ld_addr_d;
      ld_width_q <= ld_width_d;
      st_full_q  <= st_full_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      st_width_q <= st_width_d;
    end
  end

  // Transaction fields: the chosen slot while issuing, the in-flight slot while busy, else zero.
  always_comb begin
    mem_write_c = 1'b0;
    mem_addr_c  = '0;
    mem_data_c  = '0;
    mem_width_c = '0;
    if ((issue_c && pick_st_c) || (state_q == STORE_BUSY)) begin
      mem_write_c = 1'b1;
      mem_addr_c  = st_addr_q;
      mem_data_c  = st_data_q;
      mem_width_c = st_width_q;
    end else if (issue_c || (state_q == LOAD_BUSY)) begin
      mem_addr_c  = ld_addr_q;
      mem_width_c = ld_width_q;
    end
  end

`ifdef STORE_STARVATION_GUARD_EN
  localparam int unsigned StreakW = $clog2(MAX_LOAD_STREAK + 1);
  logic [StreakW-1:0] streak_q, streak_d;

  // Counts load grants that overtook a waiting store; saturates at the limit.
  always_comb begin
    streak_d = streak_q;
    if (!st_full_q || (issue_c && pick_st_c)) begin
      streak_d = '0;
    end else if (issue_c && (streak_q != StreakW'(MAX_LOAD_STREAK))) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) streak_q <= '0;
    else          streak_q <= streak_d;
  end

  assign store_wins_c = (streak_q == StreakW'(MAX_LOAD_STREAK));
`else
  assign store_wins_c = 1'b0;
`endif

  assign bus.ld_busy_o     = ld_full_q;
  assign bus.st_busy_o     = st_full_q;
  assign bus.ld_valid_o    = ld_rsp_c;
  assign bus.ld_data_o     = bus.mem_data_i;
  assign bus.st_done_o     = st_rsp_c;
  assign bus.mem_request_o = issue_c;
  assign bus.mem_write_o   = mem_write_c;
  assign bus.mem_address_o = mem_addr_c;
  assign bus.mem_data_o    = mem_data_c;
  assign bus.mem_width_o   = mem_width_c;
  assign bus.idle_o        = (state_q == IDLE) && !ld_full_q && !st_full_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level slot model.
module tb_memory_port_arbiter;
  localparam int unsigned MaxStreak = 4;
`ifdef STORE_STARVATION_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  typedef struct packed {
    logic        full;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } tslot_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   rsp_cd   = 0;

  memory_port_arbiter_if bus ();

  memory_port_arbiter #(.MAX_LOAD_STREAK(MaxStreak)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: two one-entry slots, an in-flight marker (0 none, 1 load, 2 store), a load streak.
  tslot_t m_ld = '0, m_st = '0, n_ld, n_st;
  int m_fly = 0, n_fly, m_streak = 0, n_streak;
  bit m_live = 1'b0, n_live;

  initial begin
    bit e_issue, e_pick_st, e_w;
    logic [31:0] e_a, e_d;
    logic [1:0] e_wd;
    forever begin
      @(negedge clk);
      e_issue   = (m_fly == 0) && (m_ld.full || m_st.full);
      e_pick_st = m_st.full && (!m_ld.full || (Guard && m_streak == int'(MaxStreak)));
      if (m_live) begin
        chk("ld_busy", 32'(bus.ld_busy_o), 32'(m_ld.full));
        chk("st_busy", 32'(bus.st_busy_o), 32'(m_st.full));
        chk("idle", 32'(bus.idle_o), 32'(!m_ld.full && !m_st.full && m_fly == 0));
        chk("mem_request", 32'(bus.mem_request_o), 32'(e_issue));
        e_w = 1'b0; e_a = '0; e_d = '0; e_wd = '0;
        if (e_issue ? e_pick_st : (m_fly == 2)) begin
          e_w = 1'b1; e_a = m_st.addr; e_d = m_st.data; e_wd = m_st.width;
        end else if (e_issue || m_fly == 1) begin
          e_a = m_ld.addr; e_wd = m_ld.width;
        end
        chk("mem_write", 32'(bus.mem_write_o), 32'(e_w));
        chk("mem_address", bus.mem_address_o, e_a);
        chk("mem_data", bus.mem_data_o, e_d);
        chk("mem_width", 32'(bus.mem_width_o), 32'(e_wd));
        chk("ld_valid", 32'(bus.ld_valid_o), 32'(m_fly == 1 && bus.mem_valid_i));
        if (m_fly == 1 && bus.mem_valid_i) chk("ld_data", bus.ld_data_o, bus.mem_data_i);
        chk("st_done", 32'(bus.st_done_o), 32'(m_fly == 2 && bus.mem_valid_i));
      end
      n_ld = m_ld; n_st = m_st; n_fly = m_fly; n_streak = m_streak; n_live = m_live;
      if (!rst_n) begin
        n_ld = '0; n_st = '0; n_fly = 0; n_streak = 0; n_live = 1'b1;
      end else begin
        if (m_fly == 1 && bus.mem_valid_i) begin n_ld.full = 1'b0; n_fly = 0; end
        if (m_fly == 2 && bus.mem_valid_i) begin n_st.full = 1'b0; n_fly = 0; end
        if (bus.ld_request_i && !n_ld.full)
          n_ld = {1'b1, bus.ld_address_i, 32'h0, bus.ld_width_i};
        if (bus.st_request_i && !n_st.full)
          n_st = {1'b1, bus.st_address_i, bus.st_data_i, bus.st_width_i};
        if (e_issue) n_fly = e_pick_st ? 2 : 1;
        if (!m_st.full || (e_issue && e_pick_st)) n_streak = 0;
        else if (e_issue && m_streak < int'(MaxStreak)) n_streak = m_streak + 1;
      end
      @(posedge clk);
      m_ld = n_ld; m_st = n_st; m_fly = n_fly; m_streak = n_streak; m_live = n_live;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.ld_request_i = 1'b0;
    bus.st_request_i = 1'b0;
    bus.mem_valid_i  = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Reactive controller: acks each issue two cycles later with random data.
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin bus.mem_valid_i = 1'b1; bus.mem_data_i = $urandom; end
      end
      mid();
      if (bus.mem_request_o) rsp_cd = 2;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lds;
    bit st_seen;
    rst_n = 1'b0;
    bus.ld_request_i = 1'b0; bus.ld_address_i = '0; bus.ld_width_i = '0;
    bus.st_request_i = 1'b0; bus.st_address_i = '0; bus.st_data_i = '0; bus.st_width_i = '0;
    bus.mem_valid_i  = 1'b0; bus.mem_data_i = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1;

    // Idle for 10 cycles, spurious response in cycle 3
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 3) begin bus.mem_valid_i = 1'b1; bus.mem_data_i = 32'h1234_5678; end
      mid();
      chk("reset_idle", 32'(bus.idle_o), 32'd1);
      chk("reset_no_req", 32'(bus.mem_request_o), 32'd0);
    end

    // Single load
    next_cycle(); bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h100; bus.ld_width_i = 2'd2; mid();
    next_cycle(); mid();
    chk("load_issue", 32'(bus.mem_request_o), 32'd1);
    chk("load_write", 32'(bus.mem_write_o), 32'd0);
    chk("load_addr", bus.mem_address_o, 32'h100);
    next_cycle(); mid();
    next_cycle(); mid();
    next_cycle(); bus.mem_valid_i = 1'b1; bus.mem_data_i = 32'hDEAD_BEEF; mid();
    chk("load_valid", 32'(bus.ld_valid_o), 32'd1);
    chk("load_data", bus.ld_data_o, 32'hDEAD_BEEF);
    next_cycle(); mid();
    chk("load_busy_clear", 32'(bus.ld_busy_o), 32'd0);

    // Simultaneous load and store
    next_cycle();
    bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h200;
    bus.st_request_i = 1'b1; bus.st_address_i = 32'h300; bus.st_data_i = 32'h55AA_00FF; bus.st_width_i = 2'd1;
    mid();
    next_cycle(); mid();
    chk("both_load_first", bus.mem_address_o, 32'h200);
    chk("both_load_write", 32'(bus.mem_write_o), 32'd0);
    next_cycle(); mid();
    next_cycle(); bus.mem_valid_i = 1'b1; mid();
    next_cycle(); mid();
    chk("both_store_issue", 32'(bus.mem_request_o), 32'd1);
    chk("both_store_write", 32'(bus.mem_write_o), 32'd1);
    chk("both_store_addr", bus.mem_address_o, 32'h300);
    chk("both_store_data", bus.mem_data_o, 32'h55AA_00FF);
    next_cycle(); mid();
    next_cycle(); bus.mem_valid_i = 1'b1; mid();
    chk("both_store_done", 32'(bus.st_done_o), 32'd1);
    next_cycle(); mid();
    chk("both_idle", 32'(bus.idle_o), 32'd1);

    // Protocol violation: second load while busy is dropped
    next_cycle(); bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h400; mid();
    next_cycle(); mid();
    chk("viol_first_addr", bus.mem_address_o, 32'h400);
    next_cycle(); bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h500; mid();
    next_cycle(); mid();
    chk("viol_hold_addr", bus.mem_address_o, 32'h400);
    next_cycle(); bus.mem_valid_i = 1'b1; mid();
    next_cycle(); mid();
    chk("viol_dropped_idle", 32'(bus.idle_o), 32'd1);
    chk("viol_dropped_noreq", 32'(bus.mem_request_o), 32'd0);

    // Load streak while a store waits
    next_cycle();
    bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h1000;
    bus.st_request_i = 1'b1; bus.st_address_i = 32'h2000; bus.st_data_i = 32'hCAFE_F00D;
    mid();
    lds = 0; st_seen = 1'b0; rsp_cd = 0;
    for (int c = 0; c < 100 && !st_seen; c++) begin
      next_cycle();
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin
          bus.mem_valid_i = 1'b1;
          if (lds < 6) begin bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h1000 + 32'(lds * 4); end
        end
      end
      mid();
      if (bus.mem_request_o) begin
        if (bus.mem_write_o) st_seen = 1'b1;
        else lds++;
        rsp_cd = 2;
      end
    end
    chk("streak_store_issued", 32'(st_seen), 32'd1);
    chk("streak_loads_before_store", 32'(lds), Guard ? 32'd4 : 32'd6);
    serve(16);
    chk("streak_drained", 32'(bus.idle_o), 32'd1);

    // Reset while a load is in flight, late response afterwards
    next_cycle(); bus.ld_request_i = 1'b1; bus.ld_address_i = 32'h600; mid();
    next_cycle(); mid();
    next_cycle(); rst_n = 1'b0; mid();
    next_cycle(); rst_n = 1'b1; mid();
    next_cycle(); bus.mem_valid_i = 1'b1; bus.mem_data_i = 32'hBAD0_BAD0; mid();
    chk("rst_no_ld_valid", 32'(bus.ld_valid_o), 32'd0);
    chk("rst_idle", 32'(bus.idle_o), 32'd1);

    // Randomized traffic, rare resets and spurious responses
    rsp_cd = 0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) rsp_cd = 0;
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin bus.mem_valid_i = 1'b1; bus.mem_data_i = $urandom; end
      end else if ($urandom_range(0, 31) == 0) begin
        bus.mem_valid_i = 1'b1; bus.mem_data_i = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.ld_request_i = 1'b1; bus.ld_address_i = $urandom; bus.ld_width_i = 2'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.st_request_i = 1'b1; bus.st_address_i = $urandom; bus.st_data_i = $urandom;
        bus.st_width_i = 2'($urandom_range(0, 2));
      end
      mid();
      if (bus.mem_request_o) rsp_cd = int'($urandom_range(1, 4));
    end
    rst_n = 1'b1;
    next_cycle();
    mid();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
